// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline control unit: FSM state codes,
//   stall-vector encodings, exception codes and the default handler vector.
//   Stall bit order: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_EXC_HOLD = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [31:0] EXC_INT          = 32'h00000001;
  localparam logic [31:0] EXC_SYSCALL      = 32'h00000008;
  localparam logic [31:0] EXC_INST_INVALID = 32'h0000000a;
  localparam logic [31:0] EXC_OVERFLOW     = 32'h0000000c;
  localparam logic [31:0] EXC_TRAP         = 32'h0000000d;
  localparam logic [31:0] EXC_ERET         = 32'h0000000e;

  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h00000020;

  // Stall vector for ordinary hazard requests, highest priority first.
  // The divide request is deliberately not part of this encoding.
  function automatic logic [5:0] run_stall(input logic mem, input logic ex,
                                           input logic id);
    if (mem)     return STALL_MEM;
    else if (ex) return STALL_EX;
    else if (id) return STALL_ID;
    else         return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter
//   Up-counter with enable that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   - clock
//     rst   - synchronous active-high reset, clears the count
//     en    - count this cycle
//     count - current value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (en && (count != {W{1'b1}}))
      count <= count + {{(W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Pipeline control for the five-stage core: merges stall requests,
//   sequences multi-cycle divides and performs exception/ERET redirects.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   RUN       | normal flow, stall from hazard requests
//   DIV_WAIT  | divider busy, front end held until ready or timeout
//   EXC_HOLD  | one cycle with the whole pipe frozen after an exception
//   FLUSH     | one cycle of flush with new_pc driven
//
//   Ports:
//     clk, rst                  - clock, synchronous active-high reset
//     stallreq_id/ex/mem        - hazard stall requests
//     div_req_i, div_ready_i    - divide in EX, divider result valid
//     exc_valid_i, excepttype_i - MEM-stage exception/ERET and its code
//     cp0_epc_i                 - ERET return address
//     stall[5:0]                - per-stage hold (bit0 PC ... bit5 WB)
//     flush, new_pc             - registered redirect
//     div_start_o, div_cancel_o - divider control pulses
//     div_timeout_o             - sticky divide timeout flag
//     stall_cnt                 - saturating count of PC-stall cycles
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
  parameter logic [31:0] ERET_CODE    = EXC_ERET,
  parameter int          DIV_MAX      = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        div_req_i,
  input  logic        div_ready_i,
  input  logic        exc_valid_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        div_start_o,
  output logic        div_cancel_o,
  output logic        div_timeout_o,
  output logic [31:0] stall_cnt
);

  // The counter is cleared at the start edge and advances in each
  // DIV_WAIT cycle, so in the N-th cycle after the start cycle it holds
  // N-1. Timing out when it holds DIV_MAX-2 makes the timeout cycle the
  // DIV_MAX-th cycle counted from the start cycle.
  localparam logic [5:0] DIV_LAST = 6'(DIV_MAX - 2);

  state_t      state_q, state_d;
  logic [5:0]  wait_cnt;
  logic        exc_take;
  logic        timeout_set;
  logic        timeout_q;
  logic [31:0] exc_target;

  assign exc_target = (excepttype_i == ERET_CODE) ? cp0_epc_i : HANDLER_ADDR;

  // Outputs are forced quiet while rst is high so a reset taken in
  // DIV_WAIT never emits a cancel pulse.
  always_comb begin
    state_d      = state_q;
    stall        = STALL_NONE;
    div_start_o  = 1'b0;
    div_cancel_o = 1'b0;
    exc_take     = 1'b0;
    timeout_set  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (exc_valid_i) begin
            stall    = STALL_ALL;
            exc_take = 1'b1;
            state_d  = ST_EXC_HOLD;
          end else if (stallreq_mem) begin
            stall = STALL_MEM;
          end else if (div_req_i) begin
            stall       = STALL_EX;
            div_start_o = 1'b1;
            state_d     = ST_DIV_WAIT;
          end else begin
            stall = run_stall(1'b0, stallreq_ex, stallreq_id);
          end
        end
        ST_DIV_WAIT: begin
          if (exc_valid_i) begin
            // Exception beats a coincident div_ready_i; result dropped.
            stall        = STALL_ALL;
            div_cancel_o = 1'b1;
            exc_take     = 1'b1;
            state_d      = ST_EXC_HOLD;
          end else if (div_ready_i) begin
            // Release EX this cycle so it captures the quotient.
            stall   = run_stall(stallreq_mem, stallreq_ex, stallreq_id);
            state_d = ST_RUN;
          end else if (wait_cnt == DIV_LAST) begin
            stall        = run_stall(stallreq_mem, stallreq_ex, stallreq_id);
            div_cancel_o = 1'b1;
            timeout_set  = 1'b1;
            state_d      = ST_RUN;
          end else begin
            stall = stallreq_mem ? STALL_MEM : STALL_EX;
          end
        end
        ST_EXC_HOLD: begin
          stall   = STALL_ALL;
          state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          stall   = STALL_NONE;
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wait_cnt  <= 6'd0;
      flush     <= 1'b0;
      new_pc    <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (div_start_o)
        wait_cnt <= 6'd0;
      else if (state_q == ST_DIV_WAIT)
        wait_cnt <= wait_cnt + 6'd1;
      flush <= (state_d == ST_FLUSH);
      if (exc_take)
        new_pc <= exc_target;
      if (timeout_set)
        timeout_q <= 1'b1;
    end
  end

  // Flag shows in the timeout cycle itself and then stays set.
  assign div_timeout_o = timeout_q | timeout_set;

  sat_counter #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall[0]),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        div_req_i, div_ready_i, exc_valid_i;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        div_start_o, div_cancel_o, div_timeout_o;
  logic [31:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  pipe_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .div_req_i     (div_req_i),
    .div_ready_i   (div_ready_i),
    .exc_valid_i   (exc_valid_i),
    .excepttype_i  (excepttype_i),
    .cp0_epc_i     (cp0_epc_i),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .div_start_o   (div_start_o),
    .div_cancel_o  (div_cancel_o),
    .div_timeout_o (div_timeout_o),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic       ex;
    logic       mem;
    logic       div;
    logic [5:0] exp_stall;
    logic       exp_start;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_inputs();
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    div_req_i = 0; div_ready_i = 0; exc_valid_i = 0;
    excepttype_i = 32'd0; cp0_epc_i = 32'd0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1;
    next_cyc();
    next_cyc();
    rst = 0;
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 0, 6'b000000, 0};
    vecs[1] = '{1, 0, 0, 0, 6'b000111, 0};
    vecs[2] = '{0, 1, 0, 0, 6'b001111, 0};
    vecs[3] = '{1, 1, 0, 0, 6'b001111, 0};
    vecs[4] = '{0, 0, 1, 0, 6'b011111, 0};
    vecs[5] = '{1, 0, 1, 0, 6'b011111, 0};
    vecs[6] = '{0, 1, 1, 0, 6'b011111, 0};
    vecs[7] = '{1, 1, 1, 0, 6'b011111, 0};
    vecs[8] = '{0, 0, 1, 1, 6'b011111, 0};
    vecs[9] = '{1, 1, 1, 1, 6'b011111, 0};

    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_new_pc", new_pc, 32'd0);
    chk("rst_start", 32'(div_start_o), 32'd0);
    chk("rst_cancel", 32'(div_cancel_o), 32'd0);
    chk("rst_timeout", 32'(div_timeout_o), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);

    // id for one cycle, then mem and ex together
    next_cyc();
    stallreq_id = 1;
    @(negedge clk);
    chk("t1_id_stall", 32'(stall), 32'h07);
    next_cyc();
    stallreq_id = 0; stallreq_mem = 1; stallreq_ex = 1;
    @(negedge clk);
    chk("t1_mem_ex_stall", 32'(stall), 32'h1f);
    next_cyc();
    clr_inputs();
    @(negedge clk);
    chk("t1_stall_cnt", stall_cnt, 32'd2);
    chk("t1_idle_stall", 32'(stall), 32'd0);

    // RUN encoding table, each vector held for one cycle
    for (int i = 0; i < 10; i++) begin
      next_cyc();
      stallreq_id = vecs[i].id; stallreq_ex = vecs[i].ex;
      stallreq_mem = vecs[i].mem; div_req_i = vecs[i].div;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_start", i), 32'(div_start_o), 32'(vecs[i].exp_start));
    end

    // divide with ready on cycle 35
    do_reset();
    div_req_i = 1;
    @(negedge clk);
    chk("div_c1_start", 32'(div_start_o), 32'd1);
    chk("div_c1_stall", 32'(stall), 32'h0f);
    for (int c = 2; c <= 34; c++) begin
      next_cyc();
      @(negedge clk);
      chk($sformatf("div_c%0d_stall", c), 32'(stall), 32'h0f);
      chk($sformatf("div_c%0d_start", c), 32'(div_start_o), 32'd0);
    end
    next_cyc();
    div_req_i = 0; div_ready_i = 1;
    @(negedge clk);
    chk("div_c35_stall", 32'(stall), 32'd0);
    chk("div_c35_cancel", 32'(div_cancel_o), 32'd0);
    chk("div_c35_stall_cnt", stall_cnt, 32'd34);
    next_cyc();
    div_ready_i = 0;
    @(negedge clk);
    chk("div_c36_stall", 32'(stall), 32'd0);
    chk("div_c36_timeout", 32'(div_timeout_o), 32'd0);

    // divide timeout at cycle 40
    do_reset();
    div_req_i = 1;
    @(negedge clk);
    chk("to_c1_start", 32'(div_start_o), 32'd1);
    next_cyc();
    div_req_i = 0;
    for (int c = 2; c <= 39; c++) begin
      if (c > 2) next_cyc();
      @(negedge clk);
      chk($sformatf("to_c%0d_stall", c), 32'(stall), 32'h0f);
      chk($sformatf("to_c%0d_cancel", c), 32'(div_cancel_o), 32'd0);
    end
    next_cyc();
    @(negedge clk);
    chk("to_c40_cancel", 32'(div_cancel_o), 32'd1);
    chk("to_c40_stall", 32'(stall), 32'd0);
    chk("to_c40_timeout", 32'(div_timeout_o), 32'd1);
    next_cyc();
    @(negedge clk);
    chk("to_c41_cancel", 32'(div_cancel_o), 32'd0);
    chk("to_c41_timeout", 32'(div_timeout_o), 32'd1);
    chk("to_c41_stall", 32'(stall), 32'd0);

    // exception from RUN; exc_valid_i kept high through hold and flush
    do_reset();
    exc_valid_i = 1; excepttype_i = 32'h1; cp0_epc_i = 32'h00005555;
    @(negedge clk);
    chk("exc_c0_stall", 32'(stall), 32'h3f);
    chk("exc_c0_cancel", 32'(div_cancel_o), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("exc_c1_stall", 32'(stall), 32'h3f);
    chk("exc_c1_flush", 32'(flush), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("exc_c2_flush", 32'(flush), 32'd1);
    chk("exc_c2_new_pc", new_pc, 32'h00000020);
    chk("exc_c2_stall", 32'(stall), 32'd0);
    next_cyc();
    clr_inputs();
    @(negedge clk);
    chk("exc_c3_flush", 32'(flush), 32'd0);
    chk("exc_c3_stall", 32'(stall), 32'd0);

    // ERET during DIV_WAIT coinciding with div_ready_i
    do_reset();
    div_req_i = 1;
    next_cyc();
    div_req_i = 0;
    next_cyc();
    next_cyc();
    exc_valid_i = 1; div_ready_i = 1;
    excepttype_i = 32'h0000000e; cp0_epc_i = 32'h00001234;
    @(negedge clk);
    chk("eret_cancel", 32'(div_cancel_o), 32'd1);
    chk("eret_c0_stall", 32'(stall), 32'h3f);
    next_cyc();
    clr_inputs();
    @(negedge clk);
    chk("eret_c1_stall", 32'(stall), 32'h3f);
    chk("eret_c1_cancel", 32'(div_cancel_o), 32'd0);
    chk("eret_c1_flush", 32'(flush), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("eret_c2_flush", 32'(flush), 32'd1);
    chk("eret_c2_new_pc", new_pc, 32'h00001234);
    next_cyc();
    @(negedge clk);
    chk("eret_c3_flush", 32'(flush), 32'd0);
    chk("eret_c3_timeout", 32'(div_timeout_o), 32'd0);

    // reset taken in DIV_WAIT
    do_reset();
    div_req_i = 1;
    next_cyc();
    next_cyc();
    rst = 1;
    @(negedge clk);
    chk("rdw_rst_cancel", 32'(div_cancel_o), 32'd0);
    next_cyc();
    rst = 0;
    clr_inputs();
    @(negedge clk);
    chk("rdw_stall", 32'(stall), 32'd0);
    chk("rdw_stall_cnt", stall_cnt, 32'd0);
    chk("rdw_flush", 32'(flush), 32'd0);
    chk("rdw_timeout", 32'(div_timeout_o), 32'd0);
    chk("rdw_cancel", 32'(div_cancel_o), 32'd0);

    // reset taken in EXC_HOLD
    do_reset();
    exc_valid_i = 1; excepttype_i = 32'h1;
    next_cyc();
    clr_inputs();
    rst = 1;
    next_cyc();
    rst = 0;
    @(negedge clk);
    chk("reh_flush", 32'(flush), 32'd0);
    chk("reh_new_pc", new_pc, 32'd0);
    chk("reh_stall", 32'(stall), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("reh_flush_later", 32'(flush), 32'd0);
    chk("reh_stall_later", 32'(stall), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core. Collects stall requests from ID, EX and MEM, sequences multi-cycle divide operations, and handles exception/ERET redirection. Drives the 6-bit `stall` vector consumed by the PC register and the pipeline registers, plus `flush`/`new_pc` for redirect. Also keeps a saturating stall-cycle performance counter.

## Interface
- `HANDLER_ADDR`, default 32'h00000020: exception vector loaded into `new_pc`.
- `ERET_CODE`, default 32'h0000000e: `excepttype_i` value meaning ERET; `new_pc` is then taken from `cp0_epc_i`.
- `DIV_MAX`, default 40: maximum DIV_WAIT cycles before timeout.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `stallreq_id`, input, 1: load-use hazard request from ID.
- `stallreq_ex`, input, 1: single-cycle hold request from EX.
- `stallreq_mem`, input, 1: data-bus wait from MEM.
- `div_req_i`, input, 1: EX holds a DIV/DIVU instruction.
- `div_ready_i`, input, 1: one-cycle pulse from the divider when the result is valid.
- `exc_valid_i`, input, 1: MEM-stage exception or ERET detected.
- `excepttype_i`, input, 32: exception code.
- `cp0_epc_i`, input, 32: current EPC.
- `stall`, output, 6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `flush`, output, 1: clear all pipeline registers.
- `new_pc`, output, 32: redirect target, valid while `flush`=1.
- `div_start_o`, output, 1: one-cycle start pulse to the divider.
- `div_cancel_o`, output, 1: one-cycle abort pulse to the divider.
- `div_timeout_o`, output, 1: sticky error flag, cleared only by `rst`.
- `stall_cnt`, output, 32: saturating count of cycles with `stall[0]`=1.

## Operation
- States: RUN, DIV_WAIT, EXC_HOLD, FLUSH. Reset state is RUN.
- Reset values: `stall`=0, `flush`=0, `new_pc`=0, `div_start_o`=0, `div_cancel_o`=0, `div_timeout_o`=0, `stall_cnt`=0, wait counter=0.
- Priority, highest first: `exc_valid_i`, `stallreq_mem`, divide, `stallreq_ex`, `stallreq_id`.
- RUN stall encoding:
  - `stallreq_mem` gives 6'b011111.
  - `stallreq_ex` gives 6'b001111.
  - `stallreq_id` gives 6'b000111.
  - No request gives 6'b000000.
- RUN to DIV_WAIT: when `div_req_i`=1, `exc_valid_i`=0 and `stallreq_mem`=0, pulse `div_start_o` and set `stall`=6'b001111 in the same cycle. Clear the wait counter.
- DIV_WAIT:
  - `stall`=6'b001111, or 6'b011111 if `stallreq_mem`=1.
  - The wait counter increments each cycle.
  - On `div_ready_i`=1, `stall` follows the RUN encoding in that same cycle, so EX captures the result; next state is RUN.
  - If the counter reaches `DIV_MAX` without `div_ready_i`, set `div_timeout_o`, pulse `div_cancel_o`, release the stall and return to RUN.
- Any state to EXC_HOLD on `exc_valid_i`=1:
  - `stall`=6'b111111 in the detection cycle.
  - If leaving DIV_WAIT, pulse `div_cancel_o` in that cycle.
  - Register the target: `cp0_epc_i` if `excepttype_i`==`ERET_CODE`, else `HANDLER_ADDR`.
- EXC_HOLD to FLUSH, unconditionally after one cycle (`stall`=6'b111111).
- FLUSH: `flush`=1, `new_pc`=registered target, `stall`=0, for exactly one cycle; then RUN. `exc_valid_i` is ignored in EXC_HOLD and FLUSH.
- `stall_cnt` increments on every cycle with `stall[0]`=1 and holds at 32'hFFFFFFFF.

## Timing
- `stall`, `div_start_o` and `div_cancel_o` are combinational from state and inputs, with zero-cycle response to requests.
- `flush` and `new_pc` are registered. `flush` asserts exactly 2 cycles after the `exc_valid_i` cycle.
- `div_ready_i` and `exc_valid_i` in the same cycle: the exception wins. `div_cancel_o` is still pulsed, and the result is discarded.
- `rst` asserted in any state: all outputs return to reset values on the next edge, with no cancel pulse.
- Wait counter is 6 bits, which is enough for `DIV_MAX` ≤ 63.

## Structure
- Shared defines file holds:
  - Stall encodings: STALL_NONE, STALL_ID, STALL_EX, STALL_MEM, STALL_ALL.
  - State codes.
  - Exception-code constants, including ERET.
  - `HANDLER_ADDR` default.
- One sub-module: `sat_counter` (32-bit saturating counter with enable), used for `stall_cnt`.

## Test plan
- `stallreq_id`=1 for 1 cycle, then `stallreq_mem` and `stallreq_ex` together → `stall`=6'b000111, then 6'b011111; `stall_cnt`=2.
- `div_req_i`=1, `div_ready_i` on cycle 35 → `div_start_o` 1 pulse; `stall`=6'b001111 for 34 cycles, 0 on cycle 35; `div_timeout_o`=0.
- `div_req_i`=1, no ready → at cycle 40: `div_timeout_o`=1, `div_cancel_o` pulse, `stall`=0.
- `exc_valid_i`, `excepttype_i`=32'h1 → `stall`=6'b111111 for 2 cycles, then `flush`=1, `new_pc`=32'h00000020 for 1 cycle.
- ERET with `cp0_epc_i`=32'h00001234 during DIV_WAIT → `div_cancel_o` pulse, `flush` 2 cycles later, `new_pc`=32'h00001234.
- `rst` during DIV_WAIT and during EXC_HOLD → next cycle all outputs at reset values; no `flush`.
